// File: rtl/fmap_arb_pkg.sv
// Shared types and constants for the feature-map RAM arbiter.
package fmap_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int REQ_CAM = 0;
    localparam int REQ_FET = 1;
    localparam int REQ_WB  = 2;
    localparam int REQ_AVE = 3;

    localparam int NUM_REQ_DEF = 4;
    localparam int OWN_W       = $clog2(NUM_REQ_DEF);

    // Owner-id width for an arbitrary requester count (never below 1 bit).
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_rr_picker.sv
// Combinational requester picker: round-robin from rr_ptr, or lowest index
// first when ARB_FIXED_PRIO_EN is defined.
module fmap_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDW-1:0]     win_idx,
    output logic               win_vld
);

`ifdef ARB_FIXED_PRIO_EN
    logic rr_unused;
    assign rr_unused = ^rr_ptr;

    // Descending scan so the lowest set index is written last.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDW'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int k;
        win_idx = '0;
        win_vld = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_vld && req[k]) begin
                win_idx = IDW'(k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_oh = '0;
        if (win_vld) win_oh[win_idx] = 1'b1;
    end

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Burst arbiter for the single-port feature-map RAM (cam/fet/wb/ave).
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-first selection in IDLE.
module fmap_mem_arbiter
    import fmap_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 256
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_we,
    input  logic [NUM_REQ-1:0]          i_last,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [NUM_REQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata
);

    localparam int IDW   = id_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e               state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, win_oh;
    logic [IDW-1:0]           own_q, rr_q, win_idx;
    logic                     win_vld;
    logic [CNT_W-1:0]         cnt_q;
    logic [RD_LAT-1:0]        vld_q;
    logic [RD_LAT-1:0][IDW-1:0] id_q;
    logic [RD_LAT:0]          vld_pipe;
    logic [RD_LAT:0][IDW-1:0] id_pipe;
    logic [DATA_W-1:0]        rdata_q;
    logic                     in_burst, beat, own_we, own_last, burst_end, pend;

    fmap_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req     (i_req),
        .rr_ptr  (rr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign in_burst = (state_q == GRANT);
    assign own_we   = i_we[own_q];
    assign own_last = i_last[own_q];

    // grant_q is only non-zero in GRANT, so ack is already owner-qualified.
    assign o_grant     = grant_q;
    assign o_ack       = grant_q & i_req;
    assign beat        = |o_ack;
    assign o_mem_en    = beat;
    assign o_mem_we    = beat & own_we;
    assign o_mem_addr  = in_burst ? i_addr[own_q*ADDR_W +: ADDR_W]  : '0;
    assign o_mem_wdata = in_burst ? i_wdata[own_q*DATA_W +: DATA_W] : '0;

    // Stage 0 is the read being issued now; stage RD_LAT is the one returning.
    assign vld_pipe  = {vld_q, beat & ~own_we};
    assign id_pipe   = {id_q, own_q};
    assign pend      = |vld_pipe[RD_LAT-1:0];
    assign burst_end = beat & (own_last | (cnt_q == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        o_rvalid = '0;
        if (vld_pipe[RD_LAT]) o_rvalid[id_pipe[RD_LAT]] = 1'b1;
    end

    assign o_rdata = vld_pipe[RD_LAT] ? i_mem_rdata : rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = GRANT;
            GRANT:   if (burst_end) state_d = pend ? DRAIN : IDLE;
            DRAIN:   if (!pend) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            id_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_pipe[RD_LAT-1:0];
            id_q    <= id_pipe[RD_LAT-1:0];
            if (vld_pipe[RD_LAT]) rdata_q <= i_mem_rdata;
            if (state_q == IDLE && win_vld) begin
                grant_q <= win_oh;
                own_q   <= win_idx;
                rr_q    <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
                cnt_q   <= '0;
            end else if (burst_end) begin
                grant_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
